multi_breath_led: RTL and testbench

- Multi-channel, parametrised breathing-LED PWM engine; generalisation of the single-channel fixed-timing breath LED.
- One shared prescaler, one PWM counter and one triangular brightness ramp drive CH_NUM channels.
- Each channel has a runtime mode (off / static / breath / inverted breath) and a shared brightness cap; ramp speed is set at runtime.
- Sits between board-level control registers/GPIO and the LED pins.

---
 rtl/multi_breath_led_if.sv | 25 ++
 rtl/multi_breath_led.sv | 145 ++++++++++++++
 tb/tb_multi_breath_led.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_breath_led_if.sv
// Control and LED-side signal bundle for the multi-channel breathing LED engine.
// The master drives the run/mode/brightness controls; the slave drives the LED-side results.
interface multi_breath_led_if #(
   parameter int unsigned CH_NUM  = 4,
   parameter int unsigned PWM_RES = 8,
   parameter int unsigned STEP_W  = 8
);
   logic                  en;
   logic [2*CH_NUM-1:0]   mode;
   logic [PWM_RES-1:0]    level_cap;
   logic [STEP_W-1:0]     ramp_step;
   logic [CH_NUM-1:0]     led;
   logic [PWM_RES-1:0]    level;
   logic                  cycle_done;

   modport master (
      output en, mode, level_cap, ramp_step,
      input  led, level, cycle_done
   );

   modport slave (
      input  en, mode, level_cap, ramp_step,
      output led, level, cycle_done
   );
endinterface

// File: rtl/multi_breath_led.sv
// Multi-channel breathing LED engine: one prescaler, one PWM counter and one triangular
// ramp shared by all channels. Each channel picks its duty source from a per-channel mode.
module multi_breath_led #(
   parameter int unsigned CH_NUM     = 4,
   parameter int unsigned PWM_RES    = 8,
   parameter int unsigned CLK_DIV    = 100,
   parameter int unsigned STEP_W     = 8,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input logic               sys_clk,
   input logic               sys_rst_n,
   multi_breath_led_if.slave bus
);

   localparam int unsigned        DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [PWM_RES-1:0] LMAX     = {PWM_RES{1'b1}};
   localparam logic [PWM_RES-1:0] LMAX_M1  = LMAX - PWM_RES'(1);

   typedef enum logic {StUp, StDown} dir_e;

   dir_e                            dir_q, dir_d;
   logic [DIV_W-1:0]                div_cnt_q, div_cnt_d;
   logic [PWM_RES-1:0]              pwm_cnt_q, pwm_cnt_d;
   logic [STEP_W-1:0]               step_cnt_q, step_cnt_d;
   logic [STEP_W-1:0]               step_last;
   logic [PWM_RES-1:0]              lvl_q, lvl_d;
   logic                            cycle_done_q, cycle_done_d;
   logic [CH_NUM-1:0][PWM_RES-1:0]  duty_q, duty_d;
   logic [CH_NUM-1:0]               led_q, led_d;
   logic                            tick, pwm_end, ramp_adv;

   // Timebase: prescaler, PWM counter and ramp step counter.
   always_comb begin
      tick       = (div_cnt_q == DIV_LAST);
      pwm_end    = tick && (pwm_cnt_q == LMAX_M1);
      step_last  = (bus.ramp_step == '0) ? '0 : bus.ramp_step - STEP_W'(1);
      // >= so that shrinking ramp_step mid-run advances at once instead of wrapping
      ramp_adv   = pwm_end && (step_cnt_q >= step_last);

      div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
      pwm_cnt_d  = pwm_cnt_q;
      step_cnt_d = step_cnt_q;
      if (pwm_end) begin
         pwm_cnt_d  = '0;
         step_cnt_d = ramp_adv ? '0 : step_cnt_q + STEP_W'(1);
      end else if (tick) begin
         pwm_cnt_d  = pwm_cnt_q + PWM_RES'(1);
      end
      if (!bus.en) begin
         div_cnt_d  = '0;
         pwm_cnt_d  = '0;
         step_cnt_d = '0;
      end
   end

   // Ramp direction: next-state logic.
   always_comb begin
      dir_d = dir_q;
      if (ramp_adv) begin
         unique case (dir_q)
            StUp:    if (lvl_q == LMAX) dir_d = StDown;
            StDown:  if (lvl_q == '0)   dir_d = StUp;
            default: dir_d = StUp;
         endcase
      end
      if (!bus.en) dir_d = StUp;
   end

   // Ramp direction: level and end-of-breath outputs.
   always_comb begin
      lvl_d        = lvl_q;
      cycle_done_d = 1'b0;
      if (ramp_adv) begin
         unique case (dir_q)
            StUp:    lvl_d = (lvl_q == LMAX) ? LMAX_M1 : lvl_q + PWM_RES'(1);
            StDown: begin
               if (lvl_q == '0) begin
                  lvl_d        = PWM_RES'(1);
                  cycle_done_d = 1'b1;
               end else begin
                  lvl_d = lvl_q - PWM_RES'(1);
               end
            end
            default: lvl_d = '0;
         endcase
      end
      if (!bus.en) begin
         lvl_d        = '0;
         cycle_done_d = 1'b0;
      end
   end

   // Channels: duty reloads only at the period boundary, from the post-update level.
   always_comb begin
      logic [PWM_RES-1:0] src;
      logic [PWM_RES-1:0] inv_lvl;
      duty_d  = duty_q;
      led_d   = '0;
      inv_lvl = LMAX - lvl_d;
      for (int i = 0; i < CH_NUM; i++) begin
         src = '0;
         case (bus.mode[2*i +: 2])
            2'b00: src = '0;
            2'b01: src = bus.level_cap;
            2'b10: src = (lvl_d < bus.level_cap) ? lvl_d : bus.level_cap;
            2'b11: src = (inv_lvl < bus.level_cap) ? inv_lvl : bus.level_cap;
            default: src = '0;
         endcase
         if (pwm_end) duty_d[i] = src;
         led_d[i] = (pwm_cnt_q < duty_q[i]) ^ ACTIVE_LOW;
      end
      if (!bus.en) begin
         duty_d = '0;
         led_d  = {CH_NUM{ACTIVE_LOW}};
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt_q    <= '0;
         pwm_cnt_q    <= '0;
         step_cnt_q   <= '0;
         dir_q        <= StUp;
         lvl_q        <= '0;
         cycle_done_q <= 1'b0;
         duty_q       <= '0;
         led_q        <= {CH_NUM{ACTIVE_LOW}};
      end else begin
         div_cnt_q    <= div_cnt_d;
         pwm_cnt_q    <= pwm_cnt_d;
         step_cnt_q   <= step_cnt_d;
         dir_q        <= dir_d;
         lvl_q        <= lvl_d;
         cycle_done_q <= cycle_done_d;
         duty_q       <= duty_d;
         led_q        <= led_d;
      end
   end

   assign bus.led        = led_q;
   assign bus.level      = lvl_q;
   assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_multi_breath_led.sv
// Bench for multi_breath_led (LMAX=7, 2 clocks per tick): a monitor measures every PWM period
// and checks it against expected high-counts, level and cycle_done queued by the stimulus.
module tb_multi_breath_led;

   localparam int unsigned CH_NUM  = 2;
   localparam int unsigned PWM_RES = 3;
   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned STEP_W  = 8;
   localparam int          PER     = 14;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   multi_breath_led_if #(.CH_NUM(CH_NUM), .PWM_RES(PWM_RES), .STEP_W(STEP_W)) ifc ();
   multi_breath_led_if #(.CH_NUM(CH_NUM), .PWM_RES(PWM_RES), .STEP_W(STEP_W)) ifc_al ();

   assign ifc_al.en        = ifc.en;
   assign ifc_al.mode      = ifc.mode;
   assign ifc_al.level_cap = ifc.level_cap;
   assign ifc_al.ramp_step = ifc.ramp_step;

   multi_breath_led #(
      .CH_NUM(CH_NUM), .PWM_RES(PWM_RES), .CLK_DIV(CLK_DIV), .STEP_W(STEP_W), .ACTIVE_LOW(1'b0)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (ifc)
   );

   multi_breath_led #(
      .CH_NUM(CH_NUM), .PWM_RES(PWM_RES), .CLK_DIV(CLK_DIV), .STEP_W(STEP_W), .ACTIVE_LOW(1'b1)
   ) dut_al (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (ifc_al)
   );

   typedef struct {
      int win;
      int hi0;
      int hi1;
      int lvl;
      int cd;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc;

   // Hand-derived ramp levels per PWM period after a restart (step 1 and step 4).
   int lv_a[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
   int lv_s[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 4};

   // Clock edges since the DUT last left the cleared state.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)   cyc <= 0;
      else if (!ifc.en) cyc <= 0;
      else              cyc <= cyc + 1;
   end

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic int mn(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void push(input int w, input int h0, input int h1, input int l, input int c);
      exp_t e;
      e.win = w;
      e.hi0 = h0;
      e.hi1 = h1;
      e.lvl = l;
      e.cd  = c;
      sb_q.push_back(e);
   endfunction

   // Monitor: one result per PWM period.
   initial begin
      int   a0, a1, b0, b1, cdn, lv, w, pos;
      exp_t e;
      a0 = 0; a1 = 0; b0 = 0; b1 = 0; cdn = 0; lv = 0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (cyc > 0) begin
            w   = (cyc - 1) / PER;
            pos = (cyc - 1) % PER;
            if (pos == 0) begin
               a0 = 0; a1 = 0; b0 = 0; b1 = 0; cdn = 0;
               lv = int'(ifc.level);
            end
            a0  += ifc.led[0]    ? 1 : 0;
            a1  += ifc.led[1]    ? 1 : 0;
            b0  += ifc_al.led[0] ? 0 : 1;
            b1  += ifc_al.led[1] ? 0 : 1;
            cdn += ifc.cycle_done ? 1 : 0;
            if (pos == PER - 1) begin
               while (sb_q.size() > 0 && sb_q[0].win < w) begin
                  e = sb_q.pop_front();
                  checks++;
                  failures++;
                  $display("FAIL window %0d: not observed before window %0d", e.win, w);
               end
               if (sb_q.size() > 0 && sb_q[0].win == w) begin
                  e = sb_q.pop_front();
                  chk($sformatf("w%0d ch0 high clocks", w), a0, e.hi0);
                  chk($sformatf("w%0d ch1 high clocks", w), a1, e.hi1);
                  chk($sformatf("w%0d al ch0 active clocks", w), b0, e.hi0);
                  chk($sformatf("w%0d al ch1 active clocks", w), b1, e.hi1);
                  chk($sformatf("w%0d level", w), lv, e.lvl);
                  chk($sformatf("w%0d cycle_done pulses", w), cdn, e.cd);
               end
            end
         end
      end
   end

   task automatic restart(input logic [3:0] m, input logic [2:0] cap, input logic [7:0] step);
      @(negedge sys_clk);
      ifc.en        = 1'b0;
      ifc.mode      = m;
      ifc.level_cap = cap;
      ifc.ramp_step = step;
      repeat (2) @(negedge sys_clk);
      ifc.en = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 500) begin
         @(negedge sys_clk);
         n++;
      end
      if (sb_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d periods left unchecked, 0 required", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 400 && cyc != target; i++) @(negedge sys_clk);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " led"}, int'(ifc.led), 0);
      chk({tag, " al led"}, int'(ifc_al.led), 3);
      chk({tag, " level"}, int'(ifc.level), 0);
      chk({tag, " cycle_done"}, int'(ifc.cycle_done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.en        = 1'b0;
      ifc.mode      = '0;
      ifc.level_cap = 3'd7;
      ifc.ramp_step = 8'd1;
      repeat (3) @(negedge sys_clk);
      check_idle("reset");
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      check_idle("en0");

      // Both breath, full cap: full triangle and one cycle_done.
      restart(4'b1010, 3'd7, 8'd1);
      for (int k = 0; k < 17; k++) push(k, 2*lv_a[k], 2*lv_a[k], lv_a[k], (k == 14) ? 1 : 0);
      drain();

      // ramp_step 0 behaves as 1.
      restart(4'b1010, 3'd7, 8'd0);
      for (int k = 0; k < 9; k++) push(k, 2*lv_a[k], 2*lv_a[k], lv_a[k], 0);
      drain();

      // ch0 breath, ch1 inverted breath.
      restart(4'b1110, 3'd7, 8'd1);
      for (int k = 0; k < 16; k++)
         push(k, 2*lv_a[k], (k == 0) ? 0 : 2*(7 - lv_a[k]), lv_a[k], (k == 14) ? 1 : 0);
      drain();

      // Cap 3: ch0 breath saturates, ch1 static.
      restart(4'b0110, 3'd3, 8'd1);
      for (int k = 0; k < 10; k++) push(k, 2*mn(lv_a[k], 3), (k == 0) ? 0 : 6, lv_a[k], 0);
      drain();

      // ch0 off, ch1 static.
      restart(4'b0100, 3'd3, 8'd1);
      for (int k = 0; k < 5; k++) push(k, 0, (k == 0) ? 0 : 6, lv_a[k], 0);
      drain();

      // ramp_step 4, dropped to 1 while step_cnt is 3.
      restart(4'b1010, 3'd7, 8'd4);
      for (int k = 0; k < 11; k++) push(k, 2*lv_s[k], 2*lv_s[k], lv_s[k], 0);
      wait_cyc(PER*7 + 3);
      ifc.ramp_step = 8'd1;
      drain();

      // Mode change mid-period: ch1 goes off from the next period only.
      restart(4'b1010, 3'd7, 8'd1);
      for (int k = 0; k < 6; k++) push(k, 2*lv_a[k], (k <= 3) ? 2*lv_a[k] : 0, lv_a[k], 0);
      wait_cyc(PER*3 + 5);
      ifc.mode = 4'b0010;
      drain();

      // Async reset mid-ramp.
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1 check_idle("async reset");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      ifc.mode  = 4'b1010;

      // en=0 pulse mid-ramp.
      repeat (60) @(negedge sys_clk);
      chk("level before en0", int'(ifc.level), 4);
      ifc.en = 1'b0;
      @(posedge sys_clk);
      #1 check_idle("en0 pulse");
      @(negedge sys_clk);
      ifc.en = 1'b1;
      repeat (4) @(negedge sys_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
